// File: rtl/cpu_16bit.sv
// Single-cycle 16-bit CPU with 256-word instruction and data memories.
// Instruction memory is written through a load port that works even during reset.
module cpu_16bit (
  input  logic [15:0] instruction_in,
  input  logic [15:0] load_address,
  input  logic        load_instruction,
  input  logic        clk,
  input  logic        pc_reset
);

  logic [15:0] pc;
  logic [15:0] regs [0:7];
  logic [15:0] imem [0:255] = '{default: 16'h0000};
  logic [15:0] dmem [0:255] = '{default: 16'h0000};
  logic        halted;

  logic [15:0] instr;
  logic [3:0]  op;
  logic [2:0]  rd, rs, rt;
  logic [15:0] imm;
  logic [15:0] rd_val, rs_val, rt_val;
  logic [15:0] addr_sum;
  logic [7:0]  mem_addr;
  logic [15:0] pc_inc;
  logic [15:0] pc_next;
  logic [15:0] alu_res;
  logic        reg_we;
  logic        mem_we;
  logic        halt_req;
  logic        unused_bits;

  assign instr    = imem[pc[7:0]];
  assign op       = instr[15:12];
  assign rd       = instr[11:9];
  assign rs       = instr[8:6];
  assign rt       = instr[5:3];
  assign imm      = {{10{instr[5]}}, instr[5:0]};

  // r0 is hardwired to zero on every read port
  assign rd_val   = (rd == 3'd0) ? 16'h0000 : regs[rd];
  assign rs_val   = (rs == 3'd0) ? 16'h0000 : regs[rs];
  assign rt_val   = (rt == 3'd0) ? 16'h0000 : regs[rt];

  assign addr_sum = rs_val + imm;
  assign mem_addr = addr_sum[7:0];
  assign pc_inc   = pc + 16'd1;

  assign unused_bits = ^{load_address[15:8], addr_sum[15:8]};

  always_comb begin
    alu_res  = 16'h0000;
    reg_we   = 1'b0;
    mem_we   = 1'b0;
    halt_req = 1'b0;
    pc_next  = pc_inc;
    case (op)
      4'h1: begin alu_res = rs_val + rt_val;          reg_we = 1'b1; end
      4'h2: begin alu_res = rs_val - rt_val;          reg_we = 1'b1; end
      4'h3: begin alu_res = rs_val & rt_val;          reg_we = 1'b1; end
      4'h4: begin alu_res = rs_val | rt_val;          reg_we = 1'b1; end
      4'h5: begin alu_res = rs_val ^ rt_val;          reg_we = 1'b1; end
      4'h6: begin alu_res = rs_val << rt_val[3:0];    reg_we = 1'b1; end
      4'h7: begin alu_res = rs_val >> rt_val[3:0];    reg_we = 1'b1; end
      4'h8: begin alu_res = addr_sum;                 reg_we = 1'b1; end
      4'h9: begin alu_res = dmem[mem_addr];           reg_we = 1'b1; end
      4'hA: mem_we = 1'b1;
      4'hB: if (rd_val == rs_val) pc_next = pc_inc + imm;
      4'hC: pc_next = {4'b0000, instr[11:0]};
      4'hD: begin alu_res = {instr[7:0], 8'h00};      reg_we = 1'b1; end
      4'hE: begin
        alu_res = {15'd0, $signed(rs_val) < $signed(rt_val)};
        reg_we  = 1'b1;
      end
      4'hF: begin halt_req = 1'b1; pc_next = pc; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (load_instruction) begin
      imem[load_address[7:0]] <= instruction_in;
    end
    if (pc_reset) begin
      pc     <= 16'h0000;
      halted <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        regs[i] <= 16'h0000;
      end
    end else if (!halted) begin
      pc <= pc_next;
      if (halt_req) halted <= 1'b1;
      if (reg_we && (rd != 3'd0)) regs[rd] <= alu_res;
      if (mem_we) dmem[mem_addr] <= rd_val;
    end
  end

endmodule

// File: tb/tb_cpu_16bit.sv
// Randomized and directed bench for cpu_16bit; an ISA-level model predicts state after
// every edge and a negedge monitor compares it against the DUT's visible state.
module tb_cpu_16bit;

  logic        clk = 1'b0;
  logic        pc_reset = 1'b1;
  logic        load_instruction = 1'b0;
  logic [15:0] load_address = 16'h0000;
  logic [15:0] instruction_in = 16'h0000;

  int total = 0;
  int bad   = 0;

  cpu_16bit dut (
    .instruction_in  (instruction_in),
    .load_address    (load_address),
    .load_instruction(load_instruction),
    .clk             (clk),
    .pc_reset        (pc_reset)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0]  pc;
    logic [127:0] r;
    logic         h;
  } snap_t;

  snap_t sbq[$];

  // ISA-level reference state
  logic [15:0] m_pc = 16'h0000;
  logic [15:0] m_regs [8];
  logic [15:0] m_imem [256];
  logic [15:0] m_dmem [256];
  logic        m_halted = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rv(input int idx);
    return (idx == 0) ? 0 : int'(m_regs[idx]);
  endfunction

  function automatic void wr(input int idx, input int v);
    if (idx != 0) m_regs[idx] = 16'(v);
  endfunction

  function automatic void model_exec(input logic [15:0] w);
    int op  = int'(w[15:12]);
    int rd  = int'(w[11:9]);
    int rs  = int'(w[8:6]);
    int rt  = int'(w[5:3]);
    int a   = rv(rs);
    int b   = rv(rt);
    int imm = int'(w[5:0]);
    int npc;
    int sa, sb;
    if (imm >= 32) imm -= 64;
    npc = int'(m_pc) + 1;
    case (op)
      1:  wr(rd, a + b);
      2:  wr(rd, a - b);
      3:  wr(rd, a & b);
      4:  wr(rd, a | b);
      5:  wr(rd, a ^ b);
      6:  wr(rd, a << (b % 16));
      7:  wr(rd, a >> (b % 16));
      8:  wr(rd, a + imm);
      9:  wr(rd, int'(m_dmem[(a + imm) & 255]));
      10: m_dmem[(a + imm) & 255] = 16'(rv(rd));
      11: if (rv(rd) == a) npc = int'(m_pc) + 1 + imm;
      12: npc = int'(w) & 4095;
      13: wr(rd, (int'(w) & 255) * 256);
      14: begin
        sa = (a >= 32768) ? a - 65536 : a;
        sb = (b >= 32768) ? b - 65536 : b;
        wr(rd, (sa < sb) ? 1 : 0);
      end
      15: begin m_halted = 1'b1; npc = int'(m_pc); end
      default: ;
    endcase
    m_pc = 16'(npc);
  endfunction

  function automatic void model_edge(input logic rst, input logic ld, input logic [15:0] addr,
                                     input logic [15:0] ins);
    logic [15:0] w = m_imem[m_pc[7:0]];
    if (rst) begin
      m_pc     = 16'h0000;
      m_halted = 1'b0;
      for (int i = 1; i < 8; i++) m_regs[i] = 16'h0000;
    end else if (!m_halted) begin
      model_exec(w);
    end
    if (ld) m_imem[addr[7:0]] = ins;
  endfunction

  // One clock edge of stimulus; the expected post-edge state goes to the scoreboard.
  task automatic drive(input logic rst, input logic ld, input logic [15:0] addr,
                       input logic [15:0] ins);
    snap_t s;
    @(negedge clk);
    #1;
    pc_reset         = rst;
    load_instruction = ld;
    load_address     = addr;
    instruction_in   = ins;
    model_edge(rst, ld, addr, ins);
    s.pc = m_pc;
    for (int i = 0; i < 8; i++) s.r[i*16 +: 16] = m_regs[i];
    s.h = m_halted;
    sbq.push_back(s);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic load_word(input logic [15:0] addr, input logic [15:0] w);
    drive(1'b1, 1'b1, addr, w);
  endtask

  always @(negedge clk) begin
    snap_t e;
    logic [127:0] act_r;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      for (int i = 0; i < 8; i++) act_r[i*16 +: 16] = dut.regs[i];
      chk("pc", 128'(dut.pc), 128'(e.pc));
      chk("regs", act_r, e.r);
      chk("halted", 128'(dut.halted), 128'(e.h));
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndiff;
    logic [15:0] w;
    logic [15:0] a;
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
    for (int i = 0; i < 256; i++) begin
      m_imem[i] = 16'h0000;
      m_dmem[i] = 16'h0000;
    end

    // Basic program: ADDI, negative ADDI, ADD, HALT
    load_word(16'd0, 16'h8205);
    load_word(16'd1, 16'h843D);
    load_word(16'd2, 16'h1650);
    load_word(16'd3, 16'hF000);
    chk("reset_pc", 128'(dut.pc), 128'h0);
    chk("reset_halted", 128'(dut.halted), 128'h0);
    run(5);
    chk("basic_r1", 128'(dut.regs[1]), 128'h5);
    chk("basic_r2", 128'(dut.regs[2]), 128'hFFFD);
    chk("basic_r3", 128'(dut.regs[3]), 128'h2);
    chk("basic_halted", 128'(dut.halted), 128'h1);
    chk("basic_pc", 128'(dut.pc), 128'h3);

    // Halt hold, then restart from imem[0]
    run(20);
    chk("hold_pc", 128'(dut.pc), 128'h3);
    chk("hold_r3", 128'(dut.regs[3]), 128'h2);
    drive(1'b1, 1'b0, 16'h0000, 16'h0000);
    run(2);
    chk("restart_pc", 128'(dut.pc), 128'h1);
    chk("restart_r1", 128'(dut.regs[1]), 128'h5);
    chk("restart_halted", 128'(dut.halted), 128'h0);
    run(4);

    // Store/load round trip
    load_word(16'd0, 16'h8205);
    load_word(16'd1, 16'h8243);
    load_word(16'd2, 16'hA204);
    load_word(16'd3, 16'h9804);
    load_word(16'd4, 16'hF000);
    run(8);
    chk("mem_dmem4", 128'(dut.dmem[4]), 128'h8);
    chk("mem_r4", 128'(dut.regs[4]), 128'h8);

    // LUI and r0 write discard
    load_word(16'd0, 16'hDAAB);
    load_word(16'd1, 16'h8007);
    load_word(16'd2, 16'hF000);
    run(5);
    chk("lui_r5", 128'(dut.regs[5]), 128'hAB00);
    chk("r0_zero", 128'(dut.regs[0]), 128'h0);

    // Taken branch skips one instruction
    load_word(16'd0, 16'hB001);
    load_word(16'd1, 16'h8201);
    load_word(16'd2, 16'h8402);
    load_word(16'd3, 16'hF000);
    run(6);
    chk("beq_r1", 128'(dut.regs[1]), 128'h0);
    chk("beq_r2", 128'(dut.regs[2]), 128'h2);

    // Self loop, reset mid-run
    load_word(16'd0, 16'hB03F);
    run(5);
    chk("loop_pc", 128'(dut.pc), 128'h0);
    chk("loop_halted", 128'(dut.halted), 128'h0);
    drive(1'b1, 1'b0, 16'h0000, 16'h0000);
    run(3);
    chk("loop_reset_pc", 128'(dut.pc), 128'h0);

    // Same-edge load to the fetched address executes the old word
    load_word(16'd0, 16'h8201);
    drive(1'b0, 1'b1, 16'h0000, 16'h8403);
    run(1);
    chk("hazard_r1", 128'(dut.regs[1]), 128'h1);
    chk("hazard_imem0", 128'(dut.imem[0]), 128'h8403);

    // Random programs with random loads and resets during execution
    for (int p = 0; p < 12; p++) begin
      for (int i = 0; i < 256; i++) begin
        w = 16'($urandom);
        if (w[15:12] == 4'hF && $urandom_range(0, 7) != 0) w[15:12] = 4'h1;
        load_word(16'(i), w);
      end
      for (int c = 0; c < 150; c++) begin
        if ($urandom_range(0, 49) == 0) begin
          drive(1'b1, 1'b0, 16'h0000, 16'h0000);
        end else if ($urandom_range(0, 19) == 0) begin
          a = ($urandom_range(0, 1) == 0) ? {8'h00, m_pc[7:0]} : 16'($urandom);
          w = 16'($urandom);
          if (w[15:12] == 4'hF) w[15:12] = 4'h8;
          drive(1'b0, 1'b1, a, w);
        end else begin
          run(1);
        end
      end
      // A reset edge leaves dmem untouched, so model and DUT dmem line up afterwards
      drive(1'b1, 1'b0, 16'h0000, 16'h0000);
      ndiff = 0;
      for (int i = 0; i < 256; i++) begin
        if (dut.dmem[i] !== m_dmem[i]) ndiff++;
      end
      chk("dmem_diff_count", 128'(ndiff), 128'h0);
    end

    run(1);
    @(negedge clk);
    #2;
    chk("scoreboard_drained", 128'(sbq.size()), 128'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_16bit.md
CPU_16BIT -- requirements
Module: cpu_16bit

Interface
REQ-001 Ports are connected positionally in this order: instruction_in, load_address, load_instruction, clk, pc_reset.
REQ-002 clk  input  1  single system clock; all state changes on the rising edge.
REQ-003 pc_reset  input  1  reset, synchronous and active-high.
REQ-004 instruction_in  input  16  instruction word to be written into instruction memory.
REQ-005 load_address  input  16  instruction memory write address; only bits [7:0] are used.
REQ-006 load_instruction  input  1  instruction memory write enable.
REQ-007 There are no output ports.
REQ-008 The internal state is exposed for hierarchical observation under these names:
- pc[15:0]
- regs[0:7] (16-bit each)
- imem[0:255] (16-bit)
- dmem[0:255] (16-bit)
- halted (1-bit)

Function
REQ-009 Loading: each rising edge with load_instruction=1 sets imem[load_address[7:0]] <= instruction_in, independent of pc_reset and of execution.
REQ-010 Execution is single-cycle: each rising edge with pc_reset=0 and halted=0 executes imem[pc[7:0]], using the pre-edge contents, and commits all results.
REQ-011 A same-edge load to the address being fetched does not affect the instruction executed on that edge.
REQ-012 By default pc <= pc+1, modulo 2^16; imem is indexed by pc[7:0], so fetch wraps from 255 to 0.
REQ-013 Register r0 always reads 0 and writes to it are discarded.
REQ-014 All arithmetic is 16-bit with carry and overflow discarded.
REQ-015 Instruction fields:
- op = [15:12]
- rd = [11:9]
- rs = [8:6]
- rt = [5:3]
- imm6 = [5:0], sign-extended to 16 bits
REQ-016 Opcodes:
- 0 NOP
- 1 ADD rd=rs+rt
- 2 SUB rd=rs-rt
- 3 AND rd=rs&rt
- 4 OR rd=rs|rt
- 5 XOR rd=rs^rt
- 6 SLL rd=rs<<rt[3:0]
- 7 SRL rd=rs>>rt[3:0] (logical shift)
REQ-017 Opcodes (continued):
- 8 ADDI rd=rs+imm6
- 9 LW rd=dmem[(rs+imm6)[7:0]]
- A SW dmem[(rs+imm6)[7:0]]=rd
- B BEQ: if rd==rs then pc=pc+1+imm6, else pc=pc+1
- C JMP pc={4'b0,[11:0]}
- D LUI rd={[7:0],8'h00}
- E SLT rd=(signed rs < signed rt)?1:0
- F HALT: halted<=1 and pc unchanged
REQ-018 While halted=1, no state changes except imem loads; only pc_reset clears halted.
REQ-019 The imem and dmem arrays are zero at time 0 and are never cleared by reset.

Reset
REQ-020 On a rising edge with pc_reset=1, all of the following happen:
- pc <= 0
- regs[1..7] <= 0
- halted <= 0
- no instruction executes
- dmem is unchanged
REQ-021 A load on a reset edge still writes imem (REQ-009).
REQ-022 The first instruction executes on the first rising edge where pc_reset=0, fetching imem[0].
REQ-023 Asserting pc_reset mid-program takes effect on the next edge, discarding the instruction that would have executed on that edge.

Verification
REQ-024 Load program with pc_reset=1, then release reset:
- program = 0x8205, 0x843D, 0x1650, 0xF000
- after 4 edges: r1=5, r2=0xFFFD, r3=2, halted=1, pc=3
REQ-025 Memory round-trip:
- program = 0x8205, 0x8243, 0xA204, 0x9804, 0xF000 (r1=5; r1=r1+3; SW r1 to dmem[4]; LW r4 from dmem[4])
- required: dmem[4]=8, r4=8
REQ-026 LUI and r0:
- program = 0xDAAB, 0x8007, 0xF000
- required: r5=0xAB00 and r0 still reads 0
REQ-027 Branch:
- program = 0xB001 (BEQ r0,r0,+1), 0x8201, 0x8402, 0xF000
- required: r1=0 because the instruction was skipped, r2=2
REQ-028 Reset mid-run:
- program = 0xB03F (infinite self-loop)
- assert pc_reset for 1 edge -> pc=0, halted=0, loop resumes
REQ-029 Halt hold:
- after HALT, run 20 further edges -> pc and regs are unchanged
- then pulse pc_reset -> execution restarts from imem[0]
